// File: rtl/pipe_cla_addsub_pkg.sv
// Shared constants and types for the pipelined carry-lookahead add/subtract unit.
package pipe_cla_addsub_pkg;

  localparam int unsigned DefWidth = 32;
  localparam int unsigned DefSlice = 8;
  localparam int unsigned DefTagW  = 4;

  localparam logic OpAdd = 1'b0;
  localparam logic OpSub = 1'b1;

  // Bit order {ovf, cout, zero} as seen by the writeback status register.
  typedef struct packed {
    logic ovf;
    logic cout;
    logic zero;
  } flags_t;

  function automatic logic ovf_calc(logic a_msb, logic b_msb, logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/pipe_cla_addsub_cla_slice.sv
// Combinational SLICE-bit carry-lookahead adder slice with group propagate/generate.
module cla_slice #(
  parameter int unsigned SLICE = 8
) (
  input  logic [SLICE-1:0] x_i,
  input  logic [SLICE-1:0] y_i,
  input  logic             c_i,
  output logic [SLICE-1:0] sum_o,
  output logic             p_o,
  output logic             g_o,
  output logic             c_o,
  output logic             zero_o
);

  logic [SLICE-1:0] p;
  logic [SLICE-1:0] g;
  logic [SLICE:0]   c;

  assign p = x_i ^ y_i;
  assign g = x_i & y_i;

  // Each carry is a flat prefix of G/P terms rather than a ripple chain.
  always_comb begin
    logic gg;
    logic pp;
    gg   = 1'b0;
    pp   = 1'b0;
    g_o  = 1'b0;
    c    = '0;
    c[0] = c_i;
    for (int i = 0; i < SLICE; i++) begin
      gg = g[i];
      pp = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        gg = gg | (pp & g[j]);
        pp = pp & p[j];
      end
      c[i+1] = gg | (pp & c_i);
    end
    g_o = gg;
  end

  assign p_o    = &p;
  assign c_o    = c[SLICE];
  assign sum_o  = p ^ c[SLICE-1:0];
  assign zero_o = ~|sum_o;

endmodule

// File: rtl/pipe_cla_addsub.sv
// Pipelined add/subtract: one CLA slice per stage, carry registered between stages,
// single global advance enable shared by every stage.
module pipe_cla_addsub
  import pipe_cla_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned SLICE = DefSlice,
  parameter int unsigned TAG_W = DefTagW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  input  logic [TAG_W-1:0] tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned STAGES = WIDTH / SLICE;
  localparam int unsigned Last   = STAGES - 1;

  if ((WIDTH % SLICE) != 0) begin : g_bad_param
    $error("pipe_cla_addsub: WIDTH must be a multiple of SLICE");
  end

  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic             adv;
  flags_t           out_flags;

  assign b_eff    = (sub == OpSub) ? ~b : b;
  assign c0       = (sub == OpAdd) ? cin : 1'b1;
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned SumW = (k + 1) * SLICE;

    logic [SLICE-1:0] x, y, s;
    logic             ci, co, gp, gg, sz, z_in, vin;
    logic [SumW-1:0]  sum_d;
    logic [TAG_W-1:0] tag_in;

    logic             vld_q, c_q, z_q;
    logic [SumW-1:0]  sum_q;
    logic [TAG_W-1:0] tag_q;

    if (k == 0) begin : g_head
      assign x      = a[SLICE-1:0];
      assign y      = b_eff[SLICE-1:0];
      assign ci     = c0;
      assign z_in   = 1'b1;
      assign tag_in = tag;
      assign vin    = in_valid;
      assign sum_d  = s;
    end else begin : g_body
      assign x      = g_stage[k-1].g_rem.a_rem_q[SLICE-1:0];
      assign y      = g_stage[k-1].g_rem.b_rem_q[SLICE-1:0];
      assign ci     = g_stage[k-1].c_q;
      assign z_in   = g_stage[k-1].z_q;
      assign tag_in = g_stage[k-1].tag_q;
      assign vin    = g_stage[k-1].vld_q;
      assign sum_d  = {s, g_stage[k-1].sum_q};
    end

    cla_slice #(
      .SLICE (SLICE)
    ) u_slice (
      .x_i    (x),
      .y_i    (y),
      .c_i    (ci),
      .sum_o  (s),
      .p_o    (gp),
      .g_o    (gg),
      .c_o    (co),
      .zero_o (sz)
    );

    // Group P/G only matter to a second lookahead level; one slice per stage has none.
    logic unused_grp;
    assign unused_grp = gp ^ gg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        c_q   <= 1'b0;
        z_q   <= 1'b0;
        sum_q <= '0;
        tag_q <= '0;
      end else if (adv) begin
        vld_q <= vin;
        if (vin) begin
          c_q   <= co;
          z_q   <= z_in & sz;
          sum_q <= sum_d;
          tag_q <= tag_in;
        end
      end
    end

    // Operand bits not yet consumed, shifted so the next slice sits at bit 0.
    if (k < Last) begin : g_rem
      localparam int unsigned RemW = WIDTH - SumW;
      logic [RemW-1:0] a_rem_d, b_rem_d, a_rem_q, b_rem_q;

      if (k == 0) begin : g_src_in
        assign a_rem_d = a[WIDTH-1:SLICE];
        assign b_rem_d = b_eff[WIDTH-1:SLICE];
      end else begin : g_src_prev
        assign a_rem_d = g_stage[k-1].g_rem.a_rem_q[RemW+SLICE-1:SLICE];
        assign b_rem_d = g_stage[k-1].g_rem.b_rem_q[RemW+SLICE-1:SLICE];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_rem_q <= '0;
          b_rem_q <= '0;
        end else if (adv && vin) begin
          a_rem_q <= a_rem_d;
          b_rem_q <= b_rem_d;
        end
      end
    end

    if (k == Last) begin : g_last
      logic ovf_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv && vin) begin
          ovf_q <= ovf_calc(x[SLICE-1], y[SLICE-1], s[SLICE-1]);
        end
      end
    end
  end

  assign out_flags = '{ovf: g_stage[Last].g_last.ovf_q,
                       cout: g_stage[Last].c_q,
                       zero: g_stage[Last].z_q};

  assign out_valid           = g_stage[Last].vld_q;
  assign sum                 = g_stage[Last].sum_q;
  assign out_tag             = g_stage[Last].tag_q;
  assign {ovf, cout, zero}   = out_flags;

endmodule

// File: tb/tb_pipe_cla_addsub.sv
// Scoreboard bench for pipe_cla_addsub: 4-stage instance plus a 1-stage instance.
module tb_pipe_cla_addsub;

  localparam int unsigned W  = 32;
  localparam int unsigned TW = 4;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [W-1:0]  sum;
    logic          ovf;
    logic          cout;
    logic          zero;
  } res_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          sub = 1'b0;
  logic          cin = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [TW-1:0] tag = '0;
  logic          in_ready, out_valid, cout, ovf, zero;
  logic [W-1:0]  sum;
  logic [TW-1:0] out_tag;

  logic          in_valid1 = 1'b0;
  logic          out_ready1 = 1'b1;
  logic          in_ready1, out_valid1, cout1, ovf1, zero1;
  logic [W-1:0]  sum1;
  logic [TW-1:0] out_tag1;

  int   n_assert = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_pop = -10;
  int   run_len = 0;
  int   n_pop = 0;
  res_t sb_q[$];

  pipe_cla_addsub #(.WIDTH(W), .SLICE(8), .TAG_W(TW)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .sub(sub), .cin(cin), .tag(tag), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero), .out_tag(out_tag)
  );

  pipe_cla_addsub #(.WIDTH(W), .SLICE(32), .TAG_W(TW)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .a(a), .b(b),
    .sub(sub), .cin(cin), .tag(tag), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .ovf(ovf1), .zero(zero1), .out_tag(out_tag1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                 input logic fsub, input logic fcin, input logic [TW-1:0] ftag);
    res_t       r;
    logic [W:0] full;
    logic [W-1:0] be;
    be     = fsub ? ~fb : fb;
    full   = {1'b0, fa} + {1'b0, be} + {{W{1'b0}}, (fsub ? 1'b1 : fcin)};
    r.tag  = ftag;
    r.sum  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (fa[W-1] == be[W-1]) && (full[W-1] != fa[W-1]);
    r.zero = (full[W-1:0] == '0);
    return r;
  endfunction

  // Scoreboard: compare every emitted result against the oldest pending expectation.
  always @(negedge clk) begin
    res_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_output", {63'b0, out_valid}, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("result", {25'b0, out_tag, sum, ovf, cout, zero}, {25'b0, e});
        n_pop++;
        run_len  = (cyc == last_pop + 1) ? run_len + 1 : 1;
        last_pop = cyc;
      end
    end
  end

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tsub,
                      input logic tcin, input logic [TW-1:0] ttag, input res_t texp);
    bit done;
    done = 1'b0;
    a = ta; b = tb_v; sub = tsub; cin = tcin; tag = ttag; in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back(texp);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) check("accept_timeout", {63'b0, in_ready}, 64'd1);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", sb_q.size(), 64'd0);
  endtask

  initial begin
    res_t e;
    int   pops0;
    logic [W-1:0] ra, rb;

    // Reset state, before any clock edge.
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_zero", zero, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_valid1", out_valid1, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Full carry ripple across all slices, with latency check.
    send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 4'd1, '{tag: 4'd1, sum: 32'h0, ovf: 1'b0, cout: 1'b1, zero: 1'b1});
    in_valid = 1'b0;
    check("lat_accept_edge", out_valid, 0);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      check((i < 3) ? "lat_wait" : "lat_out", out_valid, (i == 3) ? 1 : 0);
    end
    drain();

    // Signed overflow on add and on subtract; subtract with borrow ignoring cin.
    send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 4'd2, '{tag: 4'd2, sum: 32'h8000_0000, ovf: 1'b1, cout: 1'b0, zero: 1'b0});
    send(32'h8000_0000, 32'h1, 1'b1, 1'b0, 4'd3, '{tag: 4'd3, sum: 32'h7FFF_FFFF, ovf: 1'b1, cout: 1'b1, zero: 1'b0});
    send(32'd5, 32'd7, 1'b1, 1'b1, 4'd4, '{tag: 4'd4, sum: 32'hFFFF_FFFE, ovf: 1'b0, cout: 1'b0, zero: 1'b0});
    drain();

    // Back-to-back stream of 8, tags 0..7.
    run_len = 0;
    pops0 = n_pop;
    for (int t = 0; t < 8; t++) begin
      ra = $urandom; rb = (t == 5) ? ra : $urandom;
      send(ra, rb, t[0], t[1], 4'(t), model(ra, rb, t[0], t[1], 4'(t)));
    end
    drain();
    check("stream_run", run_len, 8);
    check("stream_count", n_pop - pops0, 8);

    // Backpressure with a result waiting and a new operand offered.
    pops0 = n_pop;
    out_ready = 1'b0;
    for (int t = 0; t < 4; t++) begin
      ra = $urandom; rb = $urandom;
      send(ra, rb, t[0], 1'b1, 4'(8 + t), model(ra, rb, t[0], 1'b1, 4'(8 + t)));
    end
    ra = $urandom; rb = $urandom;
    e = model(ra, rb, 1'b0, 1'b0, 4'd12);
    a = ra; b = rb; sub = 1'b0; cin = 1'b0; tag = 4'd12; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_hold", {25'b0, out_tag, sum, ovf, cout, zero}, {25'b0, sb_q[0]});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(ra, rb, 1'b0, 1'b0, 4'd12, e);
    for (int t = 0; t < 3; t++) begin
      ra = $urandom; rb = $urandom;
      send(ra, rb, 1'b1, 1'b0, 4'(13 + t), model(ra, rb, 1'b1, 1'b0, 4'(13 + t)));
    end
    drain();
    check("bp_count", n_pop - pops0, 8);

    // Reset while three operations are in flight.
    for (int t = 0; t < 3; t++) begin
      ra = $urandom; rb = $urandom;
      send(ra, rb, 1'b0, 1'b0, 4'(t), model(ra, rb, 1'b0, 1'b0, 4'(t)));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_sum", sum, 0);
    sb_q.delete();
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("post_rst_idle", out_valid, 0);
    end
    pops0 = n_pop;
    send(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 4'd9, model(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 4'd9));
    drain();
    check("post_rst_result", n_pop - pops0, 1);

    // Single-stage instance: one-cycle latency and async reset.
    ra = 32'hDEAD_BEEF; rb = 32'h2152_4111;
    e = model(ra, rb, 1'b0, 1'b1, 4'd6);
    a = ra; b = rb; sub = 1'b0; cin = 1'b1; tag = 4'd6; in_valid1 = 1'b1;
    @(negedge clk);
    check("s1_in_ready", in_ready1, 1);
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    check("s1_out_valid", out_valid1, 1);
    check("s1_result", {25'b0, out_tag1, sum1, ovf1, cout1, zero1}, {25'b0, e});
    @(posedge clk); #1;
    check("s1_bubble", out_valid1, 0);
    in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    check("s1_pre_reset", out_valid1, 1);
    #2 rst_n = 1'b0;
    #1;
    check("s1_rst_out_valid", out_valid1, 0);
    check("s1_rst_in_ready", in_ready1, 1);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("s1_post_rst", out_valid1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
